// File: rtl/reg_file_mp.sv
`default_nettype none
// ============================================================================
//  Module   : reg_file_mp
//  Purpose  : Two-read / two-write register file with a one-entry-per-cycle
//             clear sweep, optional hard-wired zero entry and optional
//             same-cycle write-to-read forwarding (REG_FILE_MP_BYPASS_EN).
//  Revision : 1.0  initial release
// ============================================================================
module reg_file_mp #(
    parameter int DATA_W        = 32,
    parameter int ADDR_W        = 5,
    parameter bit HARDWIRE_ZERO = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    output logic              busy,
    input  logic              we0,
    input  logic [ADDR_W-1:0] wa0,
    input  logic [DATA_W-1:0] wd0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] wa1,
    input  logic [DATA_W-1:0] wd1,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2
);

    localparam int                DEPTH  = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] c_last = ADDR_W'(DEPTH - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] w_cnt_nxt;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic w_idle;
    logic w_sweep_we;
    logic w_wv0;
    logic w_wv1;

    // ------------------------------------------------------------------
    // Sequencer: rst or clr (in IDLE) restarts the sweep at entry 0.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (rst) begin
            w_state_nxt = ST_CLEAR;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    if (r_cnt == c_last) begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (clr) begin
                        w_state_nxt = ST_CLEAR;
                        w_cnt_nxt   = '0;
                    end
                end
                default: begin
                    w_state_nxt = ST_CLEAR;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    assign busy       = (r_state == ST_CLEAR);
    assign w_idle     = (r_state == ST_IDLE) && !rst;
    assign w_sweep_we = (r_state == ST_CLEAR) && !rst;

    // Qualified writes; port 0 yields to port 1 on an address collision.
    assign w_wv1 = w_idle && we1 && !(HARDWIRE_ZERO && (wa1 == '0));
    assign w_wv0 = w_idle && we0 && !(HARDWIRE_ZERO && (wa0 == '0))
                   && !(w_wv1 && (wa1 == wa0));

    always_ff @(posedge clk) begin
        if (w_sweep_we) begin
            r_mem[r_cnt] <= '0;
        end else begin
            if (w_wv0) begin
                r_mem[wa0] <= wd0;
            end
            if (w_wv1) begin
                r_mem[wa1] <= wd1;
            end
        end
    end

    function automatic logic [DATA_W-1:0] f_read(input logic [ADDR_W-1:0] ra);
        logic [DATA_W-1:0] v;
        v = r_mem[ra];
`ifdef REG_FILE_MP_BYPASS_EN
        if (w_wv1 && (wa1 == ra)) begin
            v = wd1;
        end else if (w_wv0 && (wa0 == ra)) begin
            v = wd0;
        end
`else
`endif
        if (busy || (HARDWIRE_ZERO && (ra == '0))) begin
            v = '0;
        end
        return v;
    endfunction

    always_comb begin
        rd1 = f_read(ra1);
        rd2 = f_read(ra2);
    end

endmodule
`default_nettype wire
